// File: rtl/quat_mul_seq.sv
// Sequential quaternion multiplier: one shared signed multiplier walks the 16
// Hamilton partial products into four accumulators, with valid/ready on both sides.
module quat_mul_seq #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 2*IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a0,
  input  logic [IN_W-1:0]  a1,
  input  logic [IN_W-1:0]  a2,
  input  logic [IN_W-1:0]  a3,
  input  logic [IN_W-1:0]  b0,
  input  logic [IN_W-1:0]  b1,
  input  logic [IN_W-1:0]  b2,
  input  logic [IN_W-1:0]  b3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] c0,
  output logic [OUT_W-1:0] c1,
  output logic [OUT_W-1:0] c2,
  output logic [OUT_W-1:0] c3,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             k_reg;
  logic signed [IN_W-1:0] a_reg [4];
  logic signed [IN_W-1:0] b_reg [4];
  logic [OUT_W-1:0]       c_reg [4];
  logic signed [IN_W-1:0] a_in  [4];
  logic signed [IN_W-1:0] b_in  [4];

  logic                     accept;
  logic                     last_step;
  logic [1:0]               i_idx;
  logic [1:0]               j_idx;
  logic signed [IN_W-1:0]   a_sel;
  logic signed [IN_W-1:0]   b_sel;
  logic signed [2*IN_W-1:0] prod;
  logic [OUT_W-1:0]         prod_ext;
  logic [OUT_W-1:0]         term;
  logic                     neg;

  assign a_in[0] = a0;
  assign a_in[1] = a1;
  assign a_in[2] = a2;
  assign a_in[3] = a3;
  assign b_in[0] = b0;
  assign b_in[1] = b1;
  assign b_in[2] = b2;
  assign b_in[3] = b3;

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_step = (k_reg == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  // Step counter parks at 15 once DONE is reached; the next accept rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            k_reg <= 4'd0;
    else if (accept)                       k_reg <= 4'd0;
    else if (state_reg == RUN && !last_step) k_reg <= k_reg + 4'd1;
  end

  // Step k feeds output i = k[3:2] with term a_j * b_(i^j).
  assign i_idx    = k_reg[3:2];
  assign j_idx    = k_reg[1:0];
  assign a_sel    = a_reg[j_idx];
  assign b_sel    = b_reg[i_idx ^ j_idx];
  assign prod     = a_sel * b_sel;
  assign prod_ext = OUT_W'(prod);

  always_comb begin
    neg = 1'b0;
    case (i_idx)
      2'd0: neg = (j_idx != 2'd0);
      2'd1: neg = (j_idx == 2'd3);
      2'd2: neg = (j_idx == 2'd1);
      2'd3: neg = (j_idx == 2'd2);
      default: neg = 1'b0;
    endcase
  end

  assign term = neg ? (~prod_ext + 1'b1) : prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        a_reg[n] <= '0;
        b_reg[n] <= '0;
        c_reg[n] <= '0;
      end
    end else if (accept) begin
      for (int n = 0; n < 4; n++) begin
        a_reg[n] <= a_in[n];
        b_reg[n] <= b_in[n];
        c_reg[n] <= '0;
      end
    end else if (state_reg == RUN) begin
      for (int n = 0; n < 4; n++) begin
        if (i_idx == 2'(n)) c_reg[n] <= c_reg[n] + term;
      end
    end
  end

  assign c0 = c_reg[0];
  assign c1 = c_reg[1];
  assign c2 = c_reg[2];
  assign c3 = c_reg[3];

endmodule

// File: tb/tb_quat_mul_seq.sv
// Bench for quat_mul_seq: vector table, expected-result queue, backpressure and mid-run reset.
module tb_quat_mul_seq;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, busy;
  logic [IN_W-1:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [OUT_W-1:0] c0, c1, c2, c3;

  typedef struct packed {
    logic [3:0][IN_W-1:0]  a;
    logic [3:0][IN_W-1:0]  b;
    logic [3:0][OUT_W-1:0] c;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];
  vec_t sb [$];
  int   n_pass = 0;
  int   n_total = 0;

  quat_mul_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(out_valid), .out_ready(out_ready),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  // Reference Hamilton product written out term by term.
  function automatic logic [3:0][OUT_W-1:0] ham(input logic [3:0][IN_W-1:0] a,
                                                input logic [3:0][IN_W-1:0] b);
    longint x [4];
    longint y [4];
    longint r [4];
    logic [3:0][OUT_W-1:0] o;
    for (int n = 0; n < 4; n++) begin
      x[n] = longint'($signed(a[n]));
      y[n] = longint'($signed(b[n]));
    end
    r[0] = x[0]*y[0] - x[1]*y[1] - x[2]*y[2] - x[3]*y[3];
    r[1] = x[0]*y[1] + x[1]*y[0] + x[2]*y[3] - x[3]*y[2];
    r[2] = x[0]*y[2] - x[1]*y[3] + x[2]*y[0] + x[3]*y[1];
    r[3] = x[0]*y[3] + x[1]*y[2] - x[2]*y[1] + x[3]*y[0];
    for (int n = 0; n < 4; n++) o[n] = r[n][OUT_W-1:0];
    return o;
  endfunction

  function automatic vec_t mkv(input int x0, input int x1, input int x2, input int x3,
                               input int y0, input int y1, input int y2, input int y3,
                               input logic [OUT_W-1:0] e0, input logic [OUT_W-1:0] e1,
                               input logic [OUT_W-1:0] e2, input logic [OUT_W-1:0] e3);
    vec_t v;
    v.a = {IN_W'(x3), IN_W'(x2), IN_W'(x1), IN_W'(x0)};
    v.b = {IN_W'(y3), IN_W'(y2), IN_W'(y1), IN_W'(y0)};
    v.c = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_c(input string tag, input vec_t e);
    chk({tag, ".c0"}, 64'(c0), 64'(e.c[0]));
    chk({tag, ".c1"}, 64'(c1), 64'(e.c[1]));
    chk({tag, ".c2"}, 64'(c2), 64'(e.c[2]));
    chk({tag, ".c3"}, 64'(c3), 64'(e.c[3]));
  endtask

  task automatic drive(input vec_t v);
    a0 = v.a[0]; a1 = v.a[1]; a2 = v.a[2]; a3 = v.a[3];
    b0 = v.b[0]; b1 = v.b[1]; b2 = v.b[2]; b3 = v.b[3];
  endtask

  // Returns #1 after the accept edge; pushes the expected result there.
  task automatic accept_vec(input string tag, input vec_t v, output bit ok);
    int n = 0;
    drive(v);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    if (!in_ready) begin
      chk({tag, ".in_ready_wait"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 1'b0;
    $display("accept %s a=%h b=%h", tag, v.a, v.b);
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    chk({tag, ".latency"}, 64'(lat), 64'd16);
  endtask

  task automatic collect(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk_c(tag, e);
    $display("result %s c=%h %h %h %h exp=%h", tag, c0, c1, c2, c3, e.c);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit   ok;
    int   lat;
    vec_t e;
    vec_t r;

    tbl[0] = mkv(1, 0, 0, 0, 5, 6, 7, 8, 32'd5, 32'd6, 32'd7, 32'd8);
    tbl[1] = mkv(0, 1, 0, 0, 0, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'd1);
    tbl[2] = mkv(0, 0, 1, 0, 0, 1, 0, 0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF);
    tbl[3] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 32'hFFFFFFC4, 32'd12, 32'd30, 32'd24);
    tbl[4] = mkv(-32768, 0, 0, 0, -32768, 0, 0, 0, 32'h40000000, 32'd0, 32'd0, 32'd0);
    tbl[5] = mkv(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    for (int n = 6; n < NV; n++) begin
      r.a = {IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom)};
      r.b = {IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom)};
      r.c = ham(r.a, r.b);
      tbl[n] = r;
    end
    drive(tbl[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.c0", 64'(c0), 64'd0);
    chk("reset.c1", 64'(c1), 64'd0);
    chk("reset.c2", 64'(c2), 64'd0);
    chk("reset.c3", 64'(c3), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < NV; n++) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      accept_vec(tag, tbl[n], ok);
      if (ok) begin
        chk({tag, ".in_ready_low"}, 64'(in_ready), 64'd0);
        wait_done(tag, lat);
        collect(tag);
      end
    end

    // Backpressure: result must hold while new operands are offered.
    accept_vec("bp", tbl[3], ok);
    if (ok) begin
      wait_done("bp", lat);
      e = sb.pop_front();
      drive(tbl[1]);
      in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
        @(posedge clk); #1;
        chk("bp.out_valid_hold", 64'(out_valid), 64'd1);
        chk("bp.in_ready_hold", 64'(in_ready), 64'd0);
        chk_c("bp.hold", e);
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("bp.in_ready_post", 64'(in_ready), 64'd1);
      @(posedge clk);
      sb.push_back(tbl[1]);
      #1 in_valid = 1'b0;
      chk("bp.next_accepted", 64'(busy), 64'd1);
      wait_done("bp_next", lat);
      collect("bp_next");
    end

    // Reset at step k=7 discards the transaction.
    accept_vec("rst", tbl[5], ok);
    if (ok) begin
      repeat (7) @(posedge clk);
      #1;
      chk("rst.busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.c", 64'({c0, c1} | {c2, c3}), 64'd0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst.in_ready_after", 64'(in_ready), 64'd1);
      chk("rst.out_valid_after", 64'(out_valid), 64'd0);
      accept_vec("post_rst", tbl[3], ok);
      if (ok) begin
        wait_done("post_rst", lat);
        collect("post_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
